dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: core load/store

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// The core has priority. After STARVE_LIMIT consecutive denied debug
// cycles, the debug port is favoured for exactly one cycle.
// Out-of-range accesses never reach dmem and complete with an error
// response. Responses are registered and returned one cycle after the grant.
module dmem_arbiter #(
    parameter int MEM_SIZE     = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int          CW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    typedef enum logic {CORE_PRI, DBG_FORCE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;

    logic          win_we;
    logic [31:0]   win_addr;
    logic [31:0]   win_wdata;
    logic          in_range;
    logic          rd_hit;

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CORE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant decision, starvation counting and next state.
    always_comb begin
        core_gnt   = 1'b0;
        dbg_gnt    = 1'b0;
        starve_nxt = '0;
        state_nxt  = CORE_PRI;
        case (state)
            CORE_PRI: begin
                if (core_req)     core_gnt = 1'b1;
                else if (dbg_req) dbg_gnt  = 1'b1;
            end
            DBG_FORCE: begin
                if (dbg_req)       dbg_gnt  = 1'b1;
                else if (core_req) core_gnt = 1'b1;
            end
            default: ;
        endcase
        // The counter saturates, so it can never wrap back to zero.
        if (dbg_req && !dbg_gnt)
            starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
        // The forced state lasts exactly one cycle, whoever is granted.
        if (state == CORE_PRI && starve_nxt == CNT_MAX)
            state_nxt = DBG_FORCE;
    end

    // Route the winner's request onto the memory port.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (core_gnt) begin
            win_we    = core_we;
            win_addr  = core_addr;
            win_wdata = core_wdata;
        end else if (dbg_gnt) begin
            win_we    = dbg_we;
            win_addr  = dbg_addr;
            win_wdata = dbg_wdata;
        end
        in_range  = (win_addr < MEM_LIMIT);
        rd_hit    = !win_we && in_range;
        mem_we    = win_we && in_range;
        mem_addr  = win_addr;
        mem_wdata = win_wdata;
    end

    // Core response: rvalid is a one-cycle pulse; data and error hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            core_err    <= 1'b0;
        end else begin
            core_rvalid <= core_gnt;
            if (core_gnt) begin
                core_err   <= !in_range;
                core_rdata <= rd_hit ? mem_rdata : 32'h0;
            end
        end
    end

    // Debug response: rvalid is a one-cycle pulse; data and error hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
            dbg_err    <= 1'b0;
        end else begin
            dbg_rvalid <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_err   <= !in_range;
                dbg_rdata <= rd_hit ? mem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter, checked against a scoreboard.
// The stimulus side predicts the grants and the memory drive. It also
// queues the expected responses, which a separate monitor pops and
// compares when an rvalid appears. The reference model describes the
// arbitration as "how long has debug waited". It keeps a shadow copy of
// the memory contents.
module tb_dmem_arbiter;

    localparam int MEMSZ = 64;
    localparam int LIM   = 4;

    logic        clk, reset;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_SIZE(MEMSZ), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port dmem with a combinational read.
    logic [31:0] dmem [MEMSZ];
    logic        init_done = 1'b0;
    assign mem_rdata = (mem_addr < 32'(MEMSZ)) ? dmem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < MEMSZ; i++) dmem[i] <= 32'h1000_0000 + 32'(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            dmem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        cq[$], dq[$];
    logic [31:0] shadow [MEMSZ];
    int          dwait;
    int          n_cmp, n_err;
    logic        last_cg, last_dg, exp_cg, exp_dg;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit inr(input logic [31:0] a);
        return a < 32'(MEMSZ);
    endfunction

    // Reference model, evaluated mid-cycle on the currently driven inputs.
    task automatic step();
        logic        w;
        logic [31:0] a, d;
        rsp_t        r;
        @(negedge clk);
        exp_dg = dbg_req && (!core_req || dwait >= LIM);
        exp_cg = core_req && !exp_dg;
        w = 1'b0; a = 32'h0; d = 32'h0;
        if (exp_cg) begin w = core_we; a = core_addr; d = core_wdata; end
        else if (exp_dg) begin w = dbg_we; a = dbg_addr; d = dbg_wdata; end
        last_cg = core_gnt;
        last_dg = dbg_gnt;
        chk("arb", {core_gnt, dbg_gnt, mem_we, mem_addr, mem_wdata},
            {exp_cg, exp_dg, w && inr(a), a, d});
        if (exp_cg || exp_dg) begin
            r.err   = !inr(a);
            r.rdata = (!w && inr(a)) ? shadow[a[5:0]] : 32'h0;
            if (w && inr(a)) shadow[a[5:0]] = d;
            if (exp_cg) cq.push_back(r); else dq.push_back(r);
        end
        dwait = (dbg_req && !exp_dg) ? dwait + 1 : 0;
    endtask

    task automatic cycle(input logic cr, cw, input logic [31:0] ca, cd,
                         input logic dr, dw, input logic [31:0] da, dd);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
        step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every grant must yield exactly one response, on the next cycle.
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk); #2;
            if (core_rvalid) begin
                if (cq.size() == 0) chk("core_unexpected_rvalid", 1, 0);
                else begin r = cq.pop_front(); chk("core_rsp", {core_err, core_rdata}, {r.err, r.rdata}); end
            end else if (cq.size() != 0) begin
                void'(cq.pop_front());
                chk("core_missing_rvalid", 0, 1);
            end
            if (dbg_rvalid) begin
                if (dq.size() == 0) chk("dbg_unexpected_rvalid", 1, 0);
                else begin r = dq.pop_front(); chk("dbg_rsp", {dbg_err, dbg_rdata}, {r.err, r.rdata}); end
            end else if (dq.size() != 0) begin
                void'(dq.pop_front());
                chk("dbg_missing_rvalid", 0, 1);
            end
        end
    end

    initial begin
        logic [9:0]  pat;
        logic        cp, cwv, dp, dwv;
        logic [31:0] cav, cdv, dav, ddv;
        n_cmp = 0; n_err = 0; dwait = 0;
        last_cg = 0; last_dg = 0; exp_cg = 0; exp_dg = 0;
        for (int i = 0; i < MEMSZ; i++) shadow[i] = 32'h1000_0000 + 32'(i);
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {core_rvalid, core_rdata, core_err, dbg_rvalid, dbg_rdata, dbg_err, mem_we},
            '0);
        reset = 1'b0;
        idle();

        // Core write, then read back at address 5.
        cycle(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("core_write_ack", {core_rvalid, core_rdata, core_err}, {1'b1, 32'h0, 1'b0});
        cycle(1, 0, 5, 0, 0, 0, 0, 0);
        chk("core_read_5", {core_rvalid, core_rdata, core_err}, {1'b1, 32'hDEAD_BEEF, 1'b0});
        idle();

        // Both requesting continuously: C,C,C,C,D repeating.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 1, 0, 1, 0, 2, 0);
            pat[i] = last_dg;
        end
        chk("starve_pattern", pat, 10'b10000_10000);
        idle();

        // Debug out-of-range writes are blocked and flagged.
        cycle(0, 0, 0, 0, 1, 1, 32'd64, 32'h5555_AAAA);
        chk("dbg_err_64", {dbg_rvalid, dbg_err, dbg_rdata}, {1'b1, 1'b1, 32'h0});
        cycle(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        chk("dbg_err_ffffffff", {dbg_rvalid, dbg_err}, {1'b1, 1'b1});
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("dmem0_unchanged", {core_err, core_rdata}, {1'b0, 32'h1000_0000});
        idle();

        // Debug alone writes 0..3 back to back, then the core reads 2.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 1, 1, 32'(i), 32'hA0 + 32'(i));
            chk("dbg_burst_gnt", {last_dg, dbg_rvalid}, 2'b11);
        end
        cycle(1, 0, 2, 0, 0, 0, 0, 0);
        chk("core_read_dbg_data", core_rdata, 32'hA2);
        idle();

        // Force DBG_FORCE, then debug drops its request: the core wins.
        for (int i = 0; i < LIM; i++) cycle(1, 0, 3, 0, 1, 0, 4, 0);
        cycle(1, 0, 3, 0, 0, 0, 0, 0);
        chk("force_dbg_drop_core_gnt", {last_cg, last_dg}, 2'b10);
        for (int i = 0; i < LIM; i++) begin
            cycle(1, 0, 3, 0, 1, 0, 4, 0);
            chk("after_force_core_pri", {last_cg, last_dg}, 2'b10);
        end
        cycle(1, 0, 3, 0, 1, 0, 4, 0);
        chk("after_force_dbg_turn", {last_cg, last_dg}, 2'b01);
        idle();

        // Reset while a read grant is in flight: the response is dropped.
        cycle(1, 0, 7, 0, 0, 0, 0, 0);
        core_req = 1; core_we = 0; core_addr = 8; dbg_req = 0;
        step();
        #1;
        reset = 1'b1;
        cq.delete(); dq.delete(); dwait = 0;
        core_req = 0;
        #1;
        chk("async_reset_clear", {core_rvalid, core_rdata, core_err, mem_we}, '0);
        @(posedge clk); #1;
        chk("reset_held", {core_rvalid, core_rdata, dbg_rvalid, mem_we}, '0);
        reset = 1'b0;
        idle();
        for (int i = 0; i < LIM - 1; i++) cycle(1, 0, 1, 0, 1, 0, 2, 0);
        chk("post_reset_core_pri", {last_cg, last_dg}, 2'b10);
        idle();

        // Randomized traffic; requests are usually held until granted.
        cp = 0; dp = 0;
        cwv = 0; dwv = 0; cav = 0; cdv = 0; dav = 0; ddv = 0;
        for (int n = 0; n < 600; n++) begin
            if ((!cp && $urandom_range(2) != 0) || (cp && $urandom_range(19) == 0)) begin
                cp = 1; cwv = 1'($urandom); cdv = $urandom;
                case ($urandom_range(7))
                    6:       cav = 32'd64 + 32'($urandom_range(3));
                    7:       cav = $urandom | 32'h8000_0000;
                    default: cav = 32'($urandom_range(MEMSZ - 1));
                endcase
            end
            if ((!dp && $urandom_range(2) != 0) || (dp && $urandom_range(19) == 0)) begin
                dp = 1; dwv = 1'($urandom); ddv = $urandom;
                case ($urandom_range(7))
                    6:       dav = 32'hFFFF_FFFF;
                    7:       dav = 32'd64 + 32'($urandom_range(100));
                    default: dav = 32'($urandom_range(MEMSZ - 1));
                endcase
            end
            cycle(cp, cwv, cav, cdv, dp, dwv, dav, ddv);
            if (exp_cg) cp = 0;
            if (exp_dg) dp = 0;
        end
        idle();
        idle();
        chk("queues_drained", {32'(cq.size()), 32'(dq.size())}, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
